// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared types and constants for the aging-sensor readout sweep
// Contents:
//   state_e            scheduler FSM states
//   ADDR_W             width of the region address bus
//   REGION_ID_W        width of a region tag on the output stream
//   DATA_W             default width of one region readout word
//   LR01..LR37, ALU    region indices (logic regions 0..15, SoC/ALU region 16)
package readout_pkg;

  localparam int ADDR_W      = 5;
  localparam int REGION_ID_W = 5;
  localparam int DATA_W      = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } state_e;

  // Logic regions are named after their floorplan site (column digit, row digit).
  localparam logic [REGION_ID_W-1:0] LR01 = 5'd0;
  localparam logic [REGION_ID_W-1:0] LR03 = 5'd1;
  localparam logic [REGION_ID_W-1:0] LR05 = 5'd2;
  localparam logic [REGION_ID_W-1:0] LR07 = 5'd3;
  localparam logic [REGION_ID_W-1:0] LR11 = 5'd4;
  localparam logic [REGION_ID_W-1:0] LR13 = 5'd5;
  localparam logic [REGION_ID_W-1:0] LR15 = 5'd6;
  localparam logic [REGION_ID_W-1:0] LR17 = 5'd7;
  localparam logic [REGION_ID_W-1:0] LR21 = 5'd8;
  localparam logic [REGION_ID_W-1:0] LR23 = 5'd9;
  localparam logic [REGION_ID_W-1:0] LR25 = 5'd10;
  localparam logic [REGION_ID_W-1:0] LR27 = 5'd11;
  localparam logic [REGION_ID_W-1:0] LR31 = 5'd12;
  localparam logic [REGION_ID_W-1:0] LR33 = 5'd13;
  localparam logic [REGION_ID_W-1:0] LR35 = 5'd14;
  localparam logic [REGION_ID_W-1:0] LR37 = 5'd15;
  localparam logic [REGION_ID_W-1:0] ALU  = 5'd16;

endpackage

// File: rtl/readout_scheduler_if.sv
// rtl/readout_scheduler_if.sv - tagged readout beat stream toward the collector
// Signals:
//   out_valid   beat present (scheduler -> collector)
//   out_ready   collector accepts the beat (collector -> scheduler)
//   out_region  region index of the beat
//   out_addr    region address the word was read from
//   out_data    captured region word
// Modports: master = scheduler side, slave = collector side.
interface readout_scheduler_if #(
  parameter int DATA_W = 24
) ();

  logic                                 out_valid;
  logic                                 out_ready;
  logic [readout_pkg::REGION_ID_W-1:0]  out_region;
  logic [readout_pkg::ADDR_W-1:0]       out_addr;
  logic [DATA_W-1:0]                    out_data;

  modport master (
    output out_valid, out_region, out_addr, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_region, out_addr, out_data,
    output out_ready
  );

endinterface

// File: rtl/readout_region_mux.sv
// rtl/readout_region_mux.sv - combinational selection of one region word from the flat region bus
// Ports:
//   data_i  NUM_REGIONS*SLICE_W concatenated region words, region r at [r*SLICE_W +: SLICE_W]
//   sel_i   region index; indices past the last region yield zero
//   data_o  selected region word
module readout_region_mux
  import readout_pkg::*;
#(
  parameter int NUM_REGIONS = 17,
  parameter int SLICE_W     = 24
) (
  input  logic [NUM_REGIONS*SLICE_W-1:0] data_i,
  input  logic [REGION_ID_W-1:0]         sel_i,
  output logic [SLICE_W-1:0]             data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_i == REGION_ID_W'(i)) begin
        data_o = data_i[i*SLICE_W +: SLICE_W];
      end
    end
  end

endmodule

// File: rtl/readout_scheduler.sv
// rtl/readout_scheduler.sv - sweeps all region addresses and streams captured words as tagged beats
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         pulse, starts a sweep from IDLE
//   continuous_i    sampled at sweep end, 1 restarts immediately
//   abort_i         pulse, returns to IDLE from any state
//   addr_o          address broadcast to every region
//   region_data_i   concatenated region words, region r at [r*DATA_W +: DATA_W]
//   out_if          beat stream (master side)
//   busy_o          not IDLE
//   done_o          one-cycle pulse after a non-continuous sweep ends
//   sweep_cnt_o     sweeps completed since the last start, wraps
module readout_scheduler
  import readout_pkg::*;
#(
  parameter int NUM_REGIONS   = 17,
  parameter int NUM_ADDR      = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int DATA_W        = readout_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          continuous_i,
  input  logic                          abort_i,
  output logic [ADDR_W-1:0]             addr_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] region_data_i,
  readout_scheduler_if.master           out_if,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   sweep_cnt_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Loading N-1 and leaving SETTLE on zero gives exactly N settle cycles.
  localparam logic [CNT_W-1:0]       SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [REGION_ID_W-1:0] LAST_REGION = REGION_ID_W'(NUM_REGIONS - 1);
  localparam logic [ADDR_W-1:0]      LAST_ADDR   = ADDR_W'(NUM_ADDR - 1);

  state_e                  state_q, state_d;
  logic [REGION_ID_W-1:0]  r_q;
  logic [ADDR_W-1:0]       a_q;
  logic [CNT_W-1:0]        settle_q;
  logic [DATA_W-1:0]       data_q;
  logic [REGION_ID_W-1:0]  region_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [15:0]             sweep_q;
  logic                    done_q;
  logic [DATA_W-1:0]       mux_data;
  logic                    handshake;
  logic                    last_region;
  logic                    last_addr;

  readout_region_mux #(
    .NUM_REGIONS (NUM_REGIONS),
    .SLICE_W     (DATA_W)
  ) u_mux (
    .data_i (region_data_i),
    .sel_i  (r_q),
    .data_o (mux_data)
  );

  assign handshake   = (state_q == EMIT) && out_if.out_ready;
  assign last_region = (r_q == LAST_REGION);
  assign last_addr   = (a_q == LAST_ADDR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything, including a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = SETTLE;
        SETTLE:  if (settle_q == '0) state_d = CAPTURE;
        CAPTURE: state_d = EMIT;
        EMIT: begin
          if (handshake) begin
            if (!last_region) begin
              state_d = CAPTURE;
            end else if (!last_addr || continuous_i) begin
              state_d = SETTLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register only, so out_ready never reaches out_valid.
  always_comb begin
    busy_o           = (state_q != IDLE);
    out_if.out_valid = (state_q == EMIT);
  end

  // Indices, settle counter, payload and sweep bookkeeping. On abort everything is
  // frozen so the sweep count survives; a later start clears what it needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      a_q      <= '0;
      settle_q <= '0;
      data_q   <= '0;
      region_q <= '0;
      addr_q   <= '0;
      sweep_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!abort_i) begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              r_q      <= '0;
              a_q      <= '0;
              sweep_q  <= '0;
              settle_q <= SETTLE_LOAD;
            end
          end
          SETTLE: begin
            if (settle_q != '0) settle_q <= settle_q - 1'b1;
          end
          CAPTURE: begin
            data_q   <= mux_data;
            region_q <= r_q;
            addr_q   <= a_q;
          end
          EMIT: begin
            if (handshake) begin
              if (!last_region) begin
                r_q <= r_q + 1'b1;
              end else begin
                r_q      <= '0;
                settle_q <= SETTLE_LOAD;
                if (!last_addr) begin
                  a_q <= a_q + 1'b1;
                end else begin
                  a_q     <= '0;
                  sweep_q <= sweep_q + 1'b1;
                  done_q  <= !continuous_i;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign addr_o            = a_q;
  assign out_if.out_region = region_q;
  assign out_if.out_addr   = addr_q;
  assign out_if.out_data   = data_q;
  assign done_o            = done_q;
  assign sweep_cnt_o       = sweep_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// tb/tb_readout_scheduler.sv - self-checking bench for readout_scheduler
module tb_readout_scheduler;
  import readout_pkg::*;

  localparam int NR = 17;
  localparam int NA = 10;
  localparam int SC = 4;
  localparam int DW = 24;
  localparam int STALL = 7;

  typedef struct {
    bit start;
    bit abort;
    bit busy;
    bit valid;
    bit done;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_i = 1'b0;
  logic                continuous_i = 1'b0;
  logic                abort_i = 1'b0;
  logic                out_ready = 1'b0;
  logic [ADDR_W-1:0]   addr_o;
  logic [NR*DW-1:0]    region_data = '0;
  logic                busy_o;
  logic                done_o;
  logic [15:0]         sweep_cnt_o;

  readout_scheduler_if #(.DATA_W(DW)) bus ();
  assign bus.out_ready = out_ready;

  readout_scheduler #(
    .NUM_REGIONS   (NR),
    .NUM_ADDR      (NA),
    .SETTLE_CYCLES (SC),
    .DATA_W        (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .continuous_i  (continuous_i),
    .abort_i       (abort_i),
    .addr_o        (addr_o),
    .region_data_i (region_data),
    .out_if        (bus),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .sweep_cnt_o   (sweep_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int exp_idx = 0;
  int model_sweeps = 0;
  int stall_ctr = 0;
  int stall_seen = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_cyc = -1;
  int first_valid_cyc = -1;
  bit held = 1'b0;
  bit pend_final = 1'b0;
  bit pend_done = 1'b0;
  logic [33:0] hold_beat = '0;

  function automatic logic [23:0] pattern(input int r, input int a);
    return 24'hA00000 | 24'(r << 8) | 24'(a);
  endfunction

  // Region array: words become valid only after the address has been stable 3 cycles.
  logic [ADDR_W-1:0] seen_addr = '0;
  int stable_cnt = 100;
  always @(negedge clk) begin
    if (addr_o !== seen_addr) begin
      seen_addr = addr_o;
      stable_cnt = 0;
    end else if (stable_cnt < 100) begin
      stable_cnt++;
    end
    for (int r = 0; r < NR; r++)
      region_data[r*DW +: DW] = (stable_cnt >= 3) ? pattern(r, int'(seen_addr)) : (24'h5A5A00 | 24'(r));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One cycle at the negedge: pick ready, score the beat that the next edge accepts.
  task automatic step(input int mode);
    logic        rdy;
    logic [33:0] beat;
    logic [33:0] exp_beat;
    int          a_e;
    int          r_e;
    bit          pend_now;
    pend_now = pend_final;
    if (pend_final) begin
      pend_final = 1'b0;
      check("done_after_last", 64'(done_o), 64'(pend_done));
      check("busy_after_last", 64'(busy_o), 64'(!pend_done));
      check("sweep_cnt", 64'(sweep_cnt_o), 64'(model_sweeps[15:0]));
    end
    if (done_o && !pend_now) check("done_spurious", 64'(done_o), 64'(0));
    rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (mode == 1 && bus.out_valid && bus.out_region == 5'd9 && bus.out_addr == 5'd2 && stall_ctr < STALL) begin
      rdy = 1'b0;
      stall_ctr++;
      stall_seen++;
    end
    out_ready = rdy;
    beat = {bus.out_region, bus.out_addr, bus.out_data};
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.out_valid) begin
      if (held) begin
        check("payload_stable", 64'(beat), 64'(hold_beat));
        check("addr_hold", 64'(addr_o), 64'(hold_beat[28:24]));
      end
      if (rdy) begin
        a_e = exp_idx / NR;
        r_e = exp_idx % NR;
        exp_beat = {5'(r_e), 5'(a_e), pattern(r_e, a_e)};
        check("beat", 64'(beat), 64'(exp_beat));
        check("addr_o", 64'(addr_o), 64'(a_e));
        held = 1'b0;
        exp_idx++;
        if (exp_idx == NR * NA) begin
          exp_idx = 0;
          model_sweeps++;
          pend_final = 1'b1;
          pend_done = !continuous_i;
          stall_ctr = 0;
        end
      end else begin
        held = 1'b1;
        hold_beat = beat;
      end
    end else begin
      held = 1'b0;
    end
    if (done_o) begin
      done_seen++;
      done_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_start(input int mode);
    exp_idx = 0;
    model_sweeps = 0;
    held = 1'b0;
    pend_final = 1'b0;
    stall_ctr = 0;
    stall_seen = 0;
    first_valid_cyc = -1;
    cyc = 0;
    start_i = 1'b1;
    step(mode);
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int mode, input int budget);
    int d0 = done_seen;
    int n = 0;
    while (done_seen == d0 && n < budget) begin
      step(mode);
      n++;
    end
    check("done_within_budget", 64'(done_seen != d0), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   n;
    int   d_base;
    bit   start_pulsed;

    tbl[0] = '{start: 1'b1, abort: 1'b1, busy: 1'b0, valid: 1'b0, done: 1'b0};
    tbl[1] = '{start: 1'b0, abort: 1'b0, busy: 1'b0, valid: 1'b0, done: 1'b0};
    tbl[2] = '{start: 1'b1, abort: 1'b0, busy: 1'b1, valid: 1'b0, done: 1'b0};
    tbl[3] = '{start: 1'b1, abort: 1'b0, busy: 1'b1, valid: 1'b0, done: 1'b0};
    tbl[4] = '{start: 1'b0, abort: 1'b1, busy: 1'b0, valid: 1'b0, done: 1'b0};
    tbl[5] = '{start: 1'b0, abort: 1'b0, busy: 1'b0, valid: 1'b0, done: 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_addr", 64'(addr_o), 64'(0));
    check("rst_sweep_cnt", 64'(sweep_cnt_o), 64'(0));
    check("rst_payload", 64'({bus.out_region, bus.out_addr, bus.out_data}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy_o), 64'(0));

    // Start/abort interaction vectors, one cycle each
    for (int i = 0; i < 6; i++) begin
      start_i = tbl[i].start;
      abort_i = tbl[i].abort;
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      check($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(tbl[i].busy));
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].valid));
      check($sformatf("vec%0d_done", i), 64'(done_o), 64'(tbl[i].done));
      check($sformatf("vec%0d_addr", i), 64'(addr_o), 64'(0));
    end

    // Single sweep, always ready: latency, order, throughput, done
    continuous_i = 1'b0;
    do_start(0);
    check("busy_after_start", 64'(busy_o), 64'(1));
    run_until_done(0, 2000);
    check("first_valid_latency", 64'(first_valid_cyc), 64'(SC + 2));
    check("sweep_cycles", 64'(done_cyc), 64'(1 + NA * (SC + 2 * NR)));
    check("single_sweeps", 64'(model_sweeps), 64'(1));
    check("single_sweep_cnt", 64'(sweep_cnt_o), 64'(1));
    check("done_one_cycle", 64'(done_o), 64'(0));
    check("idle_after_done", 64'(busy_o), 64'(0));

    // Continuous mode for 3 sweeps, then one more ends with continuous low
    d_base = done_seen;
    start_pulsed = 1'b0;
    continuous_i = 1'b1;
    do_start(1);
    n = 0;
    while (model_sweeps < 3 && n < 10000) begin
      if (model_sweeps == 1 && exp_idx == 50 && !start_pulsed) begin
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        start_pulsed = 1'b1;
      end else begin
        step(1);
      end
      n++;
    end
    check("cont_three_sweeps", 64'(model_sweeps), 64'(3));
    continuous_i = 1'b0;
    run_until_done(1, 4000);
    check("cont_sweep_cnt", 64'(sweep_cnt_o), 64'(4));
    check("cont_done_count", 64'(done_seen - d_base), 64'(1));

    // Abort together with a handshake in EMIT, second sweep of a continuous run
    continuous_i = 1'b1;
    do_start(0);
    n = 0;
    while (!(model_sweeps == 1 && exp_idx == 40 && bus.out_valid) && n < 3000) begin
      step(0);
      n++;
    end
    check("abort_point_reached", 64'(bus.out_valid), 64'(1));
    d_base = done_seen;
    abort_i = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    continuous_i = 1'b0;
    check("abort_valid", 64'(bus.out_valid), 64'(0));
    check("abort_busy", 64'(busy_o), 64'(0));
    check("abort_sweep_cnt", 64'(sweep_cnt_o), 64'(1));
    for (int i = 0; i < 5; i++) begin
      if (done_o) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_seen - d_base), 64'(0));
    check("abort_stays_idle", 64'(busy_o), 64'(0));

    // Asynchronous reset at beat (a=3, r=5) of the second sweep
    continuous_i = 1'b1;
    do_start(0);
    n = 0;
    while (!(model_sweeps == 1 && bus.out_valid && bus.out_region == 5'd5 && bus.out_addr == 5'd3) && n < 3000) begin
      step(0);
      n++;
    end
    check("reset_point_reached", 64'(sweep_cnt_o), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_addr", 64'(addr_o), 64'(0));
    check("midrst_sweep_cnt", 64'(sweep_cnt_o), 64'(0));
    check("midrst_payload", 64'({bus.out_region, bus.out_addr, bus.out_data}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    continuous_i = 1'b0;

    // Restart from a=0,r=0 with random backpressure and a 7-cycle stall on (a=2,r=9)
    do_start(1);
    run_until_done(1, 4000);
    check("bp_sweep_cnt", 64'(sweep_cnt_o), 64'(1));
    check("bp_stall_cycles", 64'(stall_seen), 64'(STALL));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
